imm16_narrow_enc: RTL and testbench
===================================

Name: imm16_narrow_enc

Overview:
- Encodes a stream of 16-bit signed immediates into a compact byte stream. This is the encoder side of the 8-to-16 sign-extension path used by the datapath immediate decoder.
- Short form: a value representable as a sign-extended 8-bit byte is sent as 1 byte.
- Long form: any other value is sent as 3 bytes: ESC_CODE, high byte, low byte.
- Sits between the assembler/loader word stream and the byte-wide instruction memory writer. Valid/ready handshake on both sides.

Parameters:
- ESC_CODE, 8'h80, escape byte that starts a long-form frame. Never emitted as a short-form byte.
- CNT_W, 16, width of the statistics counters (used only with IMM_STATS_EN).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_data holds a word to encode
- in_ready  output  1  encoder accepts in_data this cycle
- in_data  input  16  signed immediate
- out_valid  output  1  out_data holds a byte
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  8  encoded byte
- out_last  output  1  current byte is the final byte of its frame
- short_cnt  output  CNT_W  number of short frames emitted
- long_cnt  output  CNT_W  number of long frames emitted

Behaviour:
- Fit test: fits = (in_data[15:7] all ones or all zeros) AND (in_data[7:0] != ESC_CODE).
  - Default ESC_CODE: short range is -127..127; -128 and all other values use long form.
- Output register: out_data, out_last and out_valid are registered.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable and out_valid stays 1.
- "Slot free" = !out_valid || out_ready.
- FSM states: IDLE, HI, LO. Hold register hold[15:0].
- IDLE:
  - in_ready = slot free. The input transfer is in_valid && in_ready.
  - Transfer with fits: out_data <= in_data[7:0], out_last <= 1, out_valid <= 1; stay in IDLE.
  - Transfer without fits: out_data <= ESC_CODE, out_last <= 0, out_valid <= 1, hold <= in_data; go to HI.
  - Slot free with no transfer: out_valid <= 0.
- HI:
  - in_ready = 0.
  - When out_ready: out_data <= hold[15:8], out_last <= 0, out_valid stays 1; go to LO.
- LO:
  - in_ready = 0.
  - When out_ready: out_data <= hold[7:0], out_last <= 1; go to IDLE.
- Latency: input transfer to first byte valid is 1 cycle.
- Throughput:
  - Short words: 1 word/cycle with out_ready held high.
  - Long words: 1 word per 3 cycles.
- in_ready is combinational from state, out_valid and out_ready. There is no combinational path from in_valid to outputs.
- Reset values: state=IDLE, out_valid=0, out_data=8'h00, out_last=0, hold=16'h0000, short_cnt=0, long_cnt=0.
- Reset mid-frame: the partial long frame is discarded and no further bytes of it are emitted. in_ready is 1 in the cycle after reset is released.
- Reset takes priority over any handshake in the same cycle.
- A word is never split across reset: a word accepted in the cycle reset is asserted is lost.

Optional Feature:
- Macro: IMM_STATS_EN.
- Defined:
  - short_cnt increments when a short-form byte is loaded into the output register.
  - long_cnt increments when an ESC_CODE byte is loaded.
  - Both counters wrap modulo 2^CNT_W.
- Undefined:
  - Counters are not instantiated; short_cnt and long_cnt are tied to 0.
  - Encoding behaviour is identical.

Test Plan:
- Short word: in_data=16'h0005, out_ready=1 -> next cycle out_data=8'h05, out_last=1, out_valid=1; in_ready stays 1.
- Negative short: 16'hFF81 (-127) -> single byte 8'h81, last=1. Then 16'hFF80 (-128) -> 3 bytes 80, FF, 80 with last only on the third; in_ready=0 for 2 cycles.
- Out of range: 16'h0080 -> bytes 80, 00, 80. Then 16'h1234 -> 80, 12, 34.
- Backpressure: send 16'h1234 with out_ready low for 4 cycles at each byte -> out_data holds each byte stable, no byte dropped or duplicated; in_ready=0 until the last byte is accepted.
- Back-to-back: 8 short words (0x0001..0x0008) with in_valid=1 and out_ready=1 -> 8 bytes on 8 consecutive cycles.
- Reset: assert reset while in HI after 16'h1234 -> out_valid=0 next cycle, no 12/34 bytes ever appear. With IMM_STATS_EN defined, short_cnt=0 and long_cnt=0 after reset, and after 3 short words + 2 long words the counters read 3 and 2.

Source files
------------

// File: rtl/imm16_narrow_enc.sv
// imm16_narrow_enc: packs 16-bit signed immediates into a byte stream.
// A value that survives the 8-to-16 sign extension is sent as one byte.
// Any other value is sent as ESC_CODE, high byte, low byte.
// The low byte of a short word never equals ESC_CODE, so the decoder can
// always tell the two forms apart.
// Optional feature macro: IMM_STATS_EN adds the short/long frame counters.
// Without it, short_cnt and long_cnt are tied to zero.
//
// Handshake (both ports): a byte or word moves on a rising edge where valid
// and ready are both 1. A producer holding valid keeps its data stable until
// the transfer. out_valid never waits on out_ready, and in_ready never
// depends on in_valid.
module imm16_narrow_enc #(
  parameter logic [7:0] ESC_CODE = 8'h80,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] short_cnt,
  output logic [CNT_W-1:0] long_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] hold;
  logic [15:0] hold_next;
  logic [7:0]  data_next;
  logic        last_next;
  logic        valid_next;

  logic slot_free;
  logic fits;
  logic take;

  // The output register can accept a new byte when empty or being drained.
  assign slot_free = !out_valid || out_ready;

  // Short form needs bits 15:7 all equal and a low byte that is not the escape.
  assign fits = ((&in_data[15:7]) || !(|in_data[15:7])) && (in_data[7:0] != ESC_CODE);

  // New words are only taken between frames, when the output slot is free.
  assign in_ready = (state == IDLE) && slot_free;
  assign take     = in_valid && in_ready;

  // Next-state and next output-register contents.
  always_comb begin
    state_next = state;
    hold_next  = hold;
    data_next  = out_data;
    last_next  = out_last;
    valid_next = out_valid;
    case (state)
      IDLE: begin
        if (take) begin
          valid_next = 1'b1;
          if (fits) begin
            data_next = in_data[7:0];
            last_next = 1'b1;
          end else begin
            data_next  = ESC_CODE;
            last_next  = 1'b0;
            hold_next  = in_data;
            state_next = HI;
          end
        end else if (slot_free) begin
          valid_next = 1'b0;
        end
      end
      HI: begin
        if (out_ready) begin
          data_next  = hold[15:8];
          last_next  = 1'b0;
          valid_next = 1'b1;
          state_next = LO;
        end
      end
      LO: begin
        if (out_ready) begin
          data_next  = hold[7:0];
          last_next  = 1'b1;
          valid_next = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  // State, hold and output registers; reset drops any partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hold      <= 16'h0000;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      hold      <= hold_next;
      out_data  <= data_next;
      out_last  <= last_next;
      out_valid <= valid_next;
    end
  end

`ifdef IMM_STATS_EN
  logic load_short;
  logic load_long;

  // A frame is counted when its first byte enters the output register.
  assign load_short = take && fits;
  assign load_long  = take && !fits;

  // Frame counters, wrapping naturally at their width.
  always_ff @(posedge clk) begin
    if (reset) begin
      short_cnt <= '0;
      long_cnt  <= '0;
    end else begin
      if (load_short) short_cnt <= short_cnt + 1'b1;
      if (load_long)  long_cnt  <= long_cnt + 1'b1;
    end
  end
`else
  assign short_cnt = {CNT_W{1'b0}};
  assign long_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_imm16_narrow_enc.sv
// tb_imm16_narrow_enc: randomized and directed checks of imm16_narrow_enc.
// The reference model turns each accepted word into its expected bytes using
// signed-integer range arithmetic, and a byte monitor drains them in order.
module tb_imm16_narrow_enc;

  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_last;
  logic [CNT_W-1:0] short_cnt;
  logic [CNT_W-1:0] long_cnt;

  int checks   = 0;
  int failures = 0;

  // expected {last, byte} in emission order
  logic [8:0] exp_q[$];
  int         exp_short = 0;
  int         exp_long  = 0;

  imm16_narrow_enc #(.ESC_CODE(8'h80), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .short_cnt (short_cnt),
    .long_cnt  (long_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: one accepted word -> expected bytes
  task automatic model_word(input logic [15:0] w);
    int v;
    logic [15:0] wc;
    wc = w;
    v  = int'($signed(wc));
    if (v >= -128 && v <= 127 && wc[7:0] != 8'h80) begin
      exp_q.push_back({1'b1, wc[7:0]});
      exp_short++;
    end else begin
      exp_q.push_back({1'b0, 8'h80});
      exp_q.push_back({1'b0, wc[15:8]});
      exp_q.push_back({1'b1, wc[7:0]});
      exp_long++;
    end
  endtask

  // byte monitor: runs at every falling edge for the whole simulation
  task automatic monitor_loop();
    logic       prev_stall = 1'b0;
    logic       prev_reset = 1'b1;
    logic [8:0] prev_byte  = '0;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (prev_stall && !prev_reset) begin
        checks++;
        if (!(out_valid === 1'b1 && {out_last, out_data} === prev_byte)) begin
          failures++;
          $display("FAIL stall_hold: got valid=%0b byte=%03h, required valid=1 byte=%03h",
                   out_valid, {out_last, out_data}, prev_byte);
        end
      end
      if (reset) begin
        exp_q.delete();
        exp_short = 0;
        exp_long  = 0;
      end else begin
        if (in_valid && in_ready) model_word(in_data);
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL byte_stream: got byte=%03h, required no byte", {out_last, out_data});
          end else begin
            e = exp_q.pop_front();
            if ({out_last, out_data} !== e) begin
              failures++;
              $display("FAIL byte_stream: got {last,data}=%03h, required %03h",
                       {out_last, out_data}, e);
            end
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_byte  = {out_last, out_data};
      prev_reset = reset;
    end
  endtask

  // driver: present one word and hold it until accepted; ends at posedge+1
  task automatic send_word(input logic [15:0] w);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = w;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: word %04h not accepted, required acceptance", w);
    end
  endtask

  // wait for every expected byte to leave; ends at posedge+1
  task automatic wait_drain();
    bit done = 0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) done = 1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain: %0d bytes outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: got valid=%0b data=%02h last=%0b in_ready=%0b, required 0 00 0 1",
               out_valid, out_data, out_last, in_ready);
    end
    checks++;
    if (short_cnt !== '0 || long_cnt !== '0) begin
      failures++;
      $display("FAIL reset_counters: got short=%0d long=%0d, required 0 0", short_cnt, long_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_short();
    out_ready = 1'b1;
    send_word(16'h0005);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h05 || out_last !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL short_word: got valid=%0b data=%02h last=%0b in_ready=%0b, required 1 05 1 1",
               out_valid, out_data, out_last, in_ready);
    end
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_negative();
    logic [2:0] rdy;
    logic [2:0] rdy_exp;
    out_ready = 1'b1;
    send_word(16'hFF81);
    wait_drain();
    rdy_exp = 3'b100;
    send_word(16'hFF80);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rdy[i] = in_ready;
      @(posedge clk); #1;
    end
    checks++;
    if (rdy !== rdy_exp) begin
      failures++;
      $display("FAIL neg128_in_ready: got %03b, required %03b", rdy, rdy_exp);
    end
    wait_drain();
  endtask

  task automatic test_out_of_range();
    out_ready = 1'b1;
    send_word(16'h0080);
    send_word(16'h1234);
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic [7:0] want[3];
    want[0] = 8'h80; want[1] = 8'h12; want[2] = 8'h34;
    out_ready = 1'b0;
    send_word(16'h1234);
    for (int b = 0; b < 3; b++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== want[b] || in_ready !== 1'b0) begin
          failures++;
          $display("FAIL backpressure: byte %0d got valid=%0b data=%02h in_ready=%0b, required 1 %02h 0",
                   b, out_valid, out_data, in_ready, want[b]);
        end
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_end: got valid=%0b in_ready=%0b, required 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 16'(i + 1);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || (i > 0 && (out_valid !== 1'b1 || out_data !== 8'(i)))) begin
        failures++;
        $display("FAIL back_to_back: step %0d got in_ready=%0b valid=%0b data=%02h, required 1 1 %02h",
                 i, in_ready, out_valid, out_data, i);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h08 || out_last !== 1'b1) begin
      failures++;
      $display("FAIL back_to_back_last: got valid=%0b data=%02h, required 1 08", out_valid, out_data);
    end
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_reset_mid_frame();
    int seen = 0;
    out_ready = 1'b1;
    send_word(16'h1234);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_frame: got valid=%0b in_ready=%0b, required 0 1", out_valid, in_ready);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_discard: got %0d stray bytes, required 0", seen);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stats();
    logic [15:0] words[5];
    words[0] = 16'h0001; words[1] = 16'h1234; words[2] = 16'hFFFF;
    words[3] = 16'hFF80; words[4] = 16'h007F;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_word(words[i]);
    wait_drain();
    @(negedge clk);
    checks++;
`ifdef IMM_STATS_EN
    if (int'(short_cnt) != 3 || int'(long_cnt) != 2 || exp_short != 3 || exp_long != 2) begin
      failures++;
      $display("FAIL stats: got short=%0d long=%0d, required 3 2", short_cnt, long_cnt);
    end
`else
    if (short_cnt !== '0 || long_cnt !== '0) begin
      failures++;
      $display("FAIL stats_tied: got short=%0d long=%0d, required 0 0", short_cnt, long_cnt);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int sent = 0;
    bit accepted = 0;
    logic [15:0] w;
    for (int cyc = 0; cyc < 3000 && sent < 300; cyc++) begin
      if (accepted) begin
        in_valid = 1'b0;
        sent++;
        accepted = 0;
      end
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 3))
          0: w = 16'($signed($urandom_range(0, 254)) - 127);
          1: w = ($urandom_range(0, 1) == 1) ? 16'hFF80 : 16'h0080;
          2: w = 16'($signed($urandom_range(0, 8)) - 132);
          default: w = 16'($urandom_range(0, 65535));
        endcase
        in_valid = 1'b1;
        in_data  = w;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      accepted = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (sent < 300 && !accepted) begin
      failures++;
      $display("FAIL random_budget: sent %0d words, required 300", sent);
    end
    wait_drain();
`ifdef IMM_STATS_EN
    @(negedge clk);
    checks++;
    if (int'(short_cnt) != exp_short || int'(long_cnt) != exp_long) begin
      failures++;
      $display("FAIL random_stats: got short=%0d long=%0d, required %0d %0d",
               short_cnt, long_cnt, exp_short, exp_long);
    end
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b1;
    fork
      monitor_loop();
    join_none
    test_reset();
    test_short();
    test_negative();
    test_out_of_range();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    test_stats();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
